// File: rtl/sum_pkg.sv
// ============================================================================
// sum_pkg : shared types, constants and round-robin helper for sum_arbiter
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package sum_pkg;

  localparam int DEF_DATA_W = 21;
  localparam logic [DEF_DATA_W-1:0] MAX_SAT = {1'b0, {(DEF_DATA_W-1){1'b1}}};
  localparam logic [DEF_DATA_W-1:0] MIN_SAT = {1'b1, {(DEF_DATA_W-2){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ACK  = 2'd2
  } state_t;

  // First set bit of req searching upward from last+1, wrapping at nreq (nreq <= 8).
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] last,
                                         input int nreq);
    int          idx;
    logic [2:0]  pick;
    pick = 3'd0;
    for (int i = 8; i >= 1; i--) begin
      if (i <= nreq) begin
        idx = int'(last) + i;
        if (idx >= nreq) idx = idx - nreq;
        if (req[3'(idx)]) pick = 3'(idx);
      end
    end
    return pick;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sum_arbiter_sat_add.sv
// ============================================================================
// sat_add : combinational signed adder with symmetric clamp to +/-(2^(W-1)-1)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module sat_add #(
  parameter int W = 21
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o,
  output logic         ovf_o,
  output logic         udf_o
);

  localparam logic signed [W:0] C_MAX  = {2'b00, {(W-1){1'b1}}};
  localparam logic signed [W:0] C_NMAX = -C_MAX;

  logic signed [W:0] sum_d;

  assign sum_d = $signed({a_i[W-1], a_i}) + $signed({b_i[W-1], b_i});

  // The most negative code is never emitted, keeping the range symmetric.
  always_comb begin
    y_o   = sum_d[W-1:0];
    ovf_o = 1'b0;
    udf_o = 1'b0;
    if (sum_d > C_MAX) begin
      y_o   = C_MAX[W-1:0];
      ovf_o = 1'b1;
    end else if (sum_d < C_NMAX) begin
      y_o   = C_NMAX[W-1:0];
      udf_o = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sum_arbiter.sv
// ============================================================================
// sum_arbiter : round-robin share of one saturating adder among NREQ requesters
// Option macro SUM_ARB_SATCNT_EN enables the saturation event counter.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module sum_arbiter
  import sum_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREQ   = 4,
  localparam int ID_W  = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DATA_W-1:0] a_bus,
  input  logic [NREQ*DATA_W-1:0] b_bus,
  output logic [NREQ-1:0]        ack,
  output logic [DATA_W-1:0]      result,
  output logic [ID_W-1:0]        res_id,
  output logic                   ovf,
  output logic                   udf,
  output logic                   busy,
  output logic [15:0]            sat_count
);

  state_t              state_q;
  logic [ID_W-1:0]     gnt_id_q, last_grant_q, res_id_q, pick_d;
  logic [DATA_W-1:0]   op_a_q, op_b_q, result_q, op_a_d, op_b_d, sum_d;
  logic [NREQ-1:0]     ack_q;
  logic                ovf_q, udf_q, ovf_d, udf_d;

  assign pick_d = ID_W'(rr_pick(8'(req), 3'(last_grant_q), NREQ));

  always_comb begin
    op_a_d = '0;
    op_b_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (ID_W'(i) == pick_d) begin
        op_a_d = a_bus[i*DATA_W +: DATA_W];
        op_b_d = b_bus[i*DATA_W +: DATA_W];
      end
    end
  end

  sat_add #(.W(DATA_W)) u_sat_add (
    .a_i   (op_a_q),
    .b_i   (op_b_q),
    .y_o   (sum_d),
    .ovf_o (ovf_d),
    .udf_o (udf_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      gnt_id_q     <= '0;
      last_grant_q <= ID_W'(NREQ - 1);
      op_a_q       <= '0;
      op_b_q       <= '0;
      result_q     <= '0;
      res_id_q     <= '0;
      ovf_q        <= 1'b0;
      udf_q        <= 1'b0;
      ack_q        <= '0;
    end else begin
      ack_q <= '0;
      case (state_q)
        IDLE: begin
          if (|req) begin
            gnt_id_q <= pick_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            state_q  <= LOAD;
          end
        end
        LOAD: begin
          result_q <= sum_d;
          ovf_q    <= ovf_d;
          udf_q    <= udf_d;
          res_id_q <= gnt_id_q;
          ack_q    <= NREQ'(1) << gnt_id_q;
          state_q  <= ACK;
        end
        ACK: begin
          last_grant_q <= gnt_id_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack    = ack_q;
  assign result = result_q;
  assign res_id = res_id_q;
  assign ovf    = ovf_q;
  assign udf    = udf_q;
  assign busy   = (state_q != IDLE);

`ifdef SUM_ARB_SATCNT_EN
  logic [15:0] sat_cnt_q;

  // Counts clamped results; sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      sat_cnt_q <= 16'h0000;
    end else if (state_q == LOAD && (ovf_d || udf_d) && sat_cnt_q != 16'hFFFF) begin
      sat_cnt_q <= sat_cnt_q + 16'd1;
    end
  end

  assign sat_count = sat_cnt_q;
`else
  assign sat_count = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sum_arbiter.sv
// ============================================================================
// tb_sum_arbiter : directed self-checking bench for sum_arbiter (DATA_W=21, NREQ=4)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_sum_arbiter;

  localparam int DW = 21;
  localparam int NR = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req;
  logic [NR*DW-1:0]  a_bus, b_bus;
  logic [NR-1:0]     ack;
  logic [DW-1:0]     result;
  logic [1:0]        res_id;
  logic              ovf, udf, busy;
  logic [15:0]       sat_count;

  int n_tests, n_fail, exp_sat;

  sum_arbiter #(.DATA_W(DW), .NREQ(NR)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .a_bus     (a_bus),
    .b_bus     (b_bus),
    .ack       (ack),
    .result    (result),
    .res_id    (res_id),
    .ovf       (ovf),
    .udf       (udf),
    .busy      (busy),
    .sat_count (sat_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bounded wait for any ack; lat = negedges waited, 0 if none arrived.
  task automatic wait_ack(output logic [NR-1:0] got, output int lat);
    got = '0;
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (ack != '0) begin
        got = ack;
        lat = c;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input int id, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [DW-1:0] er,
                        input logic eo, input logic eu);
    logic [NR-1:0] got;
    int            lat;
    @(negedge clk);
    a_bus[id*DW +: DW] = a;
    b_bus[id*DW +: DW] = b;
    req = NR'(1) << id;
    wait_ack(got, lat);
    check({tag, "_ack"}, 32'(got), 32'(NR'(1) << id));
    check({tag, "_lat"}, lat, 2);
    check({tag, "_res"}, 32'(result), 32'(er));
    check({tag, "_ovf"}, 32'(ovf), 32'(eo));
    check({tag, "_udf"}, 32'(udf), 32'(eu));
    check({tag, "_id"},  32'(res_id), id);
    req = '0;
`ifdef SUM_ARB_SATCNT_EN
    if (eo || eu) exp_sat++;
`endif
  endtask

  initial begin
    logic [NR-1:0] got;
    int            lat;
    int            order [5] = '{0, 1, 2, 3, 0};

    n_tests = 0;
    n_fail  = 0;
    exp_sat = 0;
    reset   = 1'b1;
    req     = '0;
    a_bus   = '0;
    b_bus   = '0;

    repeat (2) @(negedge clk);
    check("rst_ack", 32'(ack), 0);
    check("rst_res", 32'(result), 0);
    check("rst_id", 32'(res_id), 0);
    check("rst_flags", 32'({ovf, udf}), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_sat", 32'(sat_count), 0);
    reset = 1'b0;

    run_op("add",      1, 21'h000005, 21'h000003, 21'h000008, 1'b0, 1'b0);
    run_op("ovf",      2, 21'h0FFFFF, 21'h000001, 21'h0FFFFF, 1'b1, 1'b0);
    run_op("nearmax",  3, 21'h0FFFFF, 21'h1FFFFF, 21'h0FFFFE, 1'b0, 1'b0);
    run_op("udf",      0, 21'h100000, 21'h1FFFFF, 21'h100001, 1'b0, 1'b1);
    run_op("minop",    1, 21'h100000, 21'h000000, 21'h100001, 1'b0, 1'b1);
    run_op("exactmin", 2, 21'h100001, 21'h1FFFFF, 21'h100001, 1'b0, 1'b1);
    run_op("negmax",   3, 21'h100001, 21'h000000, 21'h100001, 1'b0, 1'b0);
    check("sat_count", 32'(sat_count), exp_sat);

    // Round robin with every requester held after a fresh reset.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NR; i++) begin
      a_bus[i*DW +: DW] = DW'(i * 16 + 1);
      b_bus[i*DW +: DW] = DW'(2);
    end
    req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_ack(got, lat);
      check($sformatf("rr%0d_ack", k), 32'(got), 32'(NR'(1) << order[k]));
      check($sformatf("rr%0d_lat", k), lat, (k == 0) ? 2 : 3);
      check($sformatf("rr%0d_res", k), 32'(result), order[k] * 16 + 3);
    end
    req = '0;
    @(negedge clk);

    // Reset during LOAD discards the operation.
    @(negedge clk);
    a_bus[2*DW +: DW] = 21'h000011;
    b_bus[2*DW +: DW] = 21'h000022;
    req = 4'b0100;
    @(negedge clk);
    check("mid_busy", 32'(busy), 1);
    reset = 1'b1;
    req   = '0;
    @(negedge clk);
    check("mid_ack", 32'(ack), 0);
    check("mid_res", 32'(result), 0);
    check("mid_flags", 32'({ovf, udf, busy}), 0);
    check("mid_sat", 32'(sat_count), 0);
    reset = 1'b0;
    a_bus[0*DW +: DW] = 21'h000007;
    b_bus[0*DW +: DW] = 21'h000009;
    req = 4'b1001;
    wait_ack(got, lat);
    check("post_ack", 32'(got), 32'b0001);
    check("post_res", 32'(result), 32'h10);
    check("post_id", 32'(res_id), 0);
    req = '0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
